uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Control and buffering block placed beside the UART receiver core. It owns the receiver's configuration (parity enable, parity type, prescale), applies host configuration changes only between frames, and tracks frame activity with a watchdog. It captures received bytes into a small FIFO drained by a valid/ready host port, and keeps sticky error status plus saturating error counters.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CNT_W, 8: width of each error counter.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_wr  in  1  one-cycle strobe; loads the shadow configuration.
- cfg_par_en  in  1  requested parity enable.
- cfg_par_typ  in  1  requested parity type; 1 = odd, 0 = even.
- cfg_prescale  in  6  requested oversampling prescale.
- cfg_pending  out  1  shadow configuration is loaded but not yet applied.
- rx_in  in  1  serial line, already synchronised; monitored for start-bit edges.
- rx_data  in  8  receiver P_DATA.
- rx_data_valid  in  1  receiver good-frame pulse.
- rx_par_err  in  1  receiver parity error.
- rx_stp_err  in  1  receiver stop error.
- par_en  out  1  to receiver PAR_EN.
- par_typ  out  1  to receiver PAR_TYP.
- prescale  out  6  to receiver prescale.
- rd_data  out  8  FIFO head byte.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  host accepts rd_data when rd_valid is also high.
- ovf  out  1  sticky: a good frame was dropped because the FIFO was full.
- tmo  out  1  sticky: frame watchdog expired.
- par_cnt  out  CNT_W  parity-error count.
- stp_cnt  out  CNT_W  stop-error count.
- stat_clr  in  1  clears ovf, tmo, par_cnt and stp_cnt.

## Operation
- Reset values:
  - par_en=1, par_typ=1, prescale=8.
  - cfg_pending=0, rd_valid=0, rd_data=0.
  - ovf=0, tmo=0, par_cnt=0, stp_cnt=0.
  - State is IDLE, FIFO is empty, rx_in history register is set to 1.
- Configuration:
  - cfg_wr with cfg_prescale=0 is ignored and leaves all state unchanged.
  - Any other cfg_wr loads the shadow registers and sets cfg_pending. A second cfg_wr before the change is applied overwrites the shadow.
  - Active outputs are updated only in IDLE; cfg_pending clears on the same edge.
- State machine:
  - IDLE to FRAME on a falling edge of rx_in (previous sample 1, current sample 0). The watchdog counter clears on this transition.
  - FRAME to IDLE on rx_data_valid, on an error event, or when the watchdog reaches 12*prescale cycles.
  - The watchdog counter is 10 bits wide; its limit is computed from the active prescale, which cannot change during FRAME.
  - A watchdog expiry sets tmo.
- Error event: rising edge of (rx_par_err | rx_stp_err). On that edge:
  - par_cnt increments if rx_par_err is high;
  - stp_cnt increments if rx_stp_err is high;
  - both increment if both are high.
  - Counters saturate at all-ones.
- FIFO push:
  - rx_data_valid pushes rx_data regardless of state.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and ovf is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- FIFO pop: occurs when rd_valid and rd_ready are both high. A push and a pop into an empty FIFO in the same cycle cannot happen, because rd_valid is low when the FIFO is empty.
- stat_clr has priority over a same-cycle set or increment; the result is cleared.

## Timing
- rx_data_valid in cycle t makes rd_valid high in cycle t+1 with that byte on rd_data (FIFO was empty).
- A pop in cycle t presents the next entry on rd_data, or drops rd_valid, in cycle t+1.
- A configuration change is applied one cycle after cfg_wr if the block is IDLE. Otherwise it is applied one cycle after the return to IDLE.
- Frame start is detected one cycle after rx_in falls.
- Sticky flags and counters update one cycle after their cause.
- Reset asserted mid-frame returns everything to its reset values. FIFO contents are discarded.

## Structure
- Package uart_rx_pkg holds:
  - state enum {IDLE, FRAME};
  - DEF_PAR_EN=1, DEF_PAR_TYP=1, DEF_PRESCALE=6'd8;
  - TMO_BITS=12 (bit times per watchdog limit);
  - WDOG_W=10.
- Sub-module uart_rx_fifo (parameter DEPTH):
  - pointers are log2(DEPTH)+1 bits wide;
  - full and empty are derived from the pointer MSB comparison;
  - ports: push, pop, din, dout, full, empty.

## Test plan
- Reset, then rx_data_valid with rx_data=0x09 -> rd_valid=1 next cycle with rd_data=0x09. Pop -> rd_valid=0.
- cfg_wr with par_en=0, par_typ=0, prescale=16 while in FRAME -> outputs stay 1/1/8 and cfg_pending=1. After rx_data_valid -> outputs become 0/0/16 and cfg_pending=0.
- Push 9 bytes with DEPTH=8 and rd_ready=0 -> ovf=1 and the first 8 bytes drain in order. Repeat with rd_ready=1 on the 9th push -> no overflow.
- rx_par_err pulsed 300 times -> par_cnt=255. stat_clr -> par_cnt=0.
- Falling edge of rx_in with no receiver response and prescale=8 -> tmo=1 after 96 cycles, state returns to IDLE.
- cfg_wr with prescale=0 -> no change and cfg_pending stays 0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive
// control block.
package uart_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic       DEF_PAR_EN   = 1'b1;
  localparam logic       DEF_PAR_TYP  = 1'b1;
  localparam logic [5:0] DEF_PRESCALE = 6'd8;

  localparam int TMO_BITS = 12;
  localparam int WDOG_W   = 10;

  function automatic logic [WDOG_W-1:0] wdog_limit(
    input logic [5:0] ps
  );
    return WDOG_W'(ps) * WDOG_W'(TMO_BITS);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host read port: FIFO head byte with a
// valid/ready handshake.
interface uart_rx_if;

  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with extra-MSB pointers; reads are
// combinational from the head slot.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] ONE =
    {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
    (wptr[AW-1:0] == rptr[AW-1:0]);

  assign dout = empty ? 8'h00
    : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver-side control: config shadowing, frame
// watchdog, receive FIFO and error statistics.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  input  logic [5:0]       cfg_prescale,
  output logic             cfg_pending,
  input  logic             rx_in,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  input  logic             rx_par_err,
  input  logic             rx_stp_err,
  output logic             par_en,
  output logic             par_typ,
  output logic [5:0]       prescale,
  uart_rx_if.master        rd,
  output logic             ovf,
  output logic             tmo,
  output logic [CNT_W-1:0] par_cnt,
  output logic [CNT_W-1:0] stp_cnt,
  input  logic             stat_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [WDOG_W-1:0] WD_ONE =
    WDOG_W'(1);

  state_t            state;
  logic              rx_prev;
  logic              err_prev;
  logic [WDOG_W-1:0] wdog;
  logic              sh_par_en;
  logic              sh_par_typ;
  logic [5:0]        sh_prescale;

  logic       fall;
  logic       err_now;
  logic       err_rise;
  logic       cfg_ok;
  logic       wdog_hit;
  logic       wdog_exp;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_ok;
  logic       drop;
  logic [7:0] fifo_dout;

  assign fall     = rx_prev & ~rx_in;
  assign err_now  = rx_par_err | rx_stp_err;
  assign err_rise = err_now & ~err_prev;
  assign cfg_ok   = cfg_wr &&
    (cfg_prescale != 6'd0);

  assign wdog_hit = (wdog ==
    (wdog_limit(prescale) - WD_ONE));
  assign wdog_exp = (state == FRAME) &&
    !rx_data_valid && !err_rise && wdog_hit;

  assign pop     = rd.rd_valid & rd.rd_ready;
  assign push_ok = rx_data_valid & (~full | pop);
  assign drop    = rx_data_valid & full & ~pop;

  assign rd.rd_valid = ~empty;
  assign rd.rd_data  = fifo_dout;

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      err_prev    <= 1'b0;
      wdog        <= '0;
      sh_par_en   <= DEF_PAR_EN;
      sh_par_typ  <= DEF_PAR_TYP;
      sh_prescale <= DEF_PRESCALE;
      par_en      <= DEF_PAR_EN;
      par_typ     <= DEF_PAR_TYP;
      prescale    <= DEF_PRESCALE;
      cfg_pending <= 1'b0;
    end else begin
      rx_prev  <= rx_in;
      err_prev <= err_now;
      if (cfg_ok) begin
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
        sh_prescale <= cfg_prescale;
      end
      // A write landing on the apply edge stays
      // pending for the next IDLE cycle.
      if (cfg_ok)
        cfg_pending <= 1'b1;
      else if (state == IDLE)
        cfg_pending <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_pending) begin
            par_en   <= sh_par_en;
            par_typ  <= sh_par_typ;
            prescale <= sh_prescale;
          end
          if (fall) begin
            state <= FRAME;
            wdog  <= '0;
          end
        end
        FRAME: begin
          if (rx_data_valid || err_rise ||
              wdog_hit)
            state <= IDLE;
          else
            wdog <= wdog + WD_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      ovf     <= 1'b0;
      tmo     <= 1'b0;
      par_cnt <= '0;
      stp_cnt <= '0;
    end else begin
      if (drop)     ovf <= 1'b1;
      if (wdog_exp) tmo <= 1'b1;
      if (err_rise && rx_par_err &&
          par_cnt != '1)
        par_cnt <= par_cnt + CNT_ONE;
      if (err_rise && rx_stp_err &&
          stp_cnt != '1)
        stp_cnt <= stp_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: queue model of
// the FIFO, counter model and directed frame cases.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic             cfg_par_en = 1'b0;
  logic             cfg_par_typ = 1'b0;
  logic [5:0]       cfg_prescale = 6'd0;
  logic             cfg_pending;
  logic             rx_in = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_data_valid = 1'b0;
  logic             rx_par_err = 1'b0;
  logic             rx_stp_err = 1'b0;
  logic             par_en;
  logic             par_typ;
  logic [5:0]       prescale;
  logic             ovf;
  logic             tmo;
  logic [CNT_W-1:0] par_cnt;
  logic [CNT_W-1:0] stp_cnt;
  logic             stat_clr = 1'b0;

  uart_rx_if rif ();

  uart_rx_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_prescale  (cfg_prescale),
    .cfg_pending   (cfg_pending),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_err    (rx_par_err),
    .rx_stp_err    (rx_stp_err),
    .par_en        (par_en),
    .par_typ       (par_typ),
    .prescale      (prescale),
    .rd            (rif.master),
    .ovf           (ovf),
    .tmo           (tmo),
    .par_cnt       (par_cnt),
    .stp_cnt       (stp_cnt),
    .stat_clr      (stat_clr)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic       exp_ovf = 1'b0;
  int         m_par = 0;
  int         m_stp = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Host-side monitor: each accepted byte must be
  // the oldest one the model has queued.
  always @(negedge clk) begin : mon
    logic [7:0] b;
    if (!rst && rif.rd_valid === 1'b1 &&
        rif.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_pop: got %0d expected none",
                 rif.rd_data);
      end else begin
        b = exp_q.pop_front();
        chk("rd_data", {24'd0, rif.rd_data},
            {24'd0, b});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b,
                      input logic rdy);
    int occ;
    occ = exp_q.size();
    rif.rd_ready  = rdy;
    rx_data       = b;
    rx_data_valid = 1'b1;
    if (occ < DEPTH || (rdy && occ > 0))
      exp_q.push_back(b);
    else
      exp_ovf = 1'b1;
    step();
    rx_data_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    rif.rd_ready = 1'b1;
    while (exp_q.size() != 0 && n < 4 * DEPTH) begin
      step();
      n++;
    end
    step();
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_rd_valid"}, {31'd0, rif.rd_valid}, 0);
    rif.rd_ready = 1'b0;
  endtask

  task automatic cfg(input logic pe,
                     input logic pt,
                     input logic [5:0] ps);
    cfg_wr       = 1'b1;
    cfg_par_en   = pe;
    cfg_par_typ  = pt;
    cfg_prescale = ps;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic chk_cfg(input string nm,
                         input logic pe,
                         input logic pt,
                         input logic [5:0] ps,
                         input logic pend);
    chk({nm, "_par_en"}, {31'd0, par_en}, {31'd0, pe});
    chk({nm, "_par_typ"}, {31'd0, par_typ},
        {31'd0, pt});
    chk({nm, "_prescale"}, {26'd0, prescale},
        {26'd0, ps});
    chk({nm, "_pending"}, {31'd0, cfg_pending},
        {31'd0, pend});
  endtask

  task automatic clr_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    m_par   = 0;
    m_stp   = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic err_pulse(input logic pe,
                           input logic se,
                           input logic clr);
    rx_par_err = pe;
    rx_stp_err = se;
    stat_clr   = clr;
    if (clr) begin
      m_par = 0;
      m_stp = 0;
    end else begin
      if (pe && m_par < 255) m_par++;
      if (se && m_stp < 255) m_stp++;
    end
    step();
    rx_par_err = 1'b0;
    rx_stp_err = 1'b0;
    stat_clr   = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rif.rd_ready  = 1'b0;
    rx_data_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    m_par   = 0;
    m_stp   = 0;
  endtask

  task automatic chk_reset(input string nm);
    chk_cfg(nm, 1'b1, 1'b1, 6'd8, 1'b0);
    chk({nm, "_rd_valid"}, {31'd0, rif.rd_valid}, 0);
    chk({nm, "_rd_data"}, {24'd0, rif.rd_data}, 0);
    chk({nm, "_ovf"}, {31'd0, ovf}, 0);
    chk({nm, "_tmo"}, {31'd0, tmo}, 0);
    chk({nm, "_par_cnt"}, {24'd0, par_cnt}, 0);
    chk({nm, "_stp_cnt"}, {24'd0, stp_cnt}, 0);
  endtask

  task automatic frame_start();
    rx_in = 1'b0;
    step();
    rx_in = 1'b1;
  endtask

  task automatic tmo_run(input string nm,
                         input int lim);
    int n;
    clr_stats();
    frame_start();
    n = 0;
    while (tmo !== 1'b1 && n < 2 * lim) begin
      step();
      n++;
    end
    chk({nm, "_set"}, {31'd0, tmo}, 1);
    chk({nm, "_latency_ok"},
        {31'd0, (n >= lim - 6 && n <= lim + 4)}, 1);
  endtask

  initial begin : stim
    int k;
    rif.rd_ready = 1'b0;
    do_reset();
    chk_reset("reset");

    push(8'h09, 1'b0);
    chk("first_valid", {31'd0, rif.rd_valid}, 1);
    chk("first_data", {24'd0, rif.rd_data}, 32'h09);
    drain("first");

    frame_start();
    step();
    cfg(1'b0, 1'b0, 6'd16);
    step();
    step();
    chk_cfg("cfg_in_frame", 1'b1, 1'b1, 6'd8, 1'b1);
    push(8'h5A, 1'b1);
    step();
    step();
    chk_cfg("cfg_after_frame", 1'b0, 1'b0, 6'd16,
            1'b0);
    drain("cfg");
    cfg(1'b1, 1'b1, 6'd8);
    step();
    step();
    chk_cfg("cfg_idle", 1'b1, 1'b1, 6'd8, 1'b0);

    cfg(1'b0, 1'b0, 6'd0);
    step();
    step();
    chk_cfg("cfg_zero", 1'b1, 1'b1, 6'd8, 1'b0);

    clr_stats();
    for (int i = 0; i < DEPTH + 1; i++)
      push(8'($urandom), 1'b0);
    step();
    chk("ovf_full", {31'd0, ovf}, {31'd0, exp_ovf});
    drain("ovf");
    clr_stats();
    chk("ovf_clr", {31'd0, ovf}, 0);
    for (int i = 0; i < DEPTH; i++)
      push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b1);
    step();
    chk("ovf_pop_same", {31'd0, ovf},
        {31'd0, exp_ovf});
    drain("ovf2");

    clr_stats();
    for (int i = 0; i < 300; i++)
      err_pulse(1'b1, 1'b0, 1'b0);
    chk("par_sat", {24'd0, par_cnt}, m_par);
    chk("stp_zero", {24'd0, stp_cnt}, m_stp);
    k = $urandom_range(1, 20);
    for (int i = 0; i < k; i++)
      err_pulse(1'b1, 1'b1, 1'b0);
    chk("par_both", {24'd0, par_cnt}, m_par);
    chk("stp_both", {24'd0, stp_cnt}, m_stp);
    err_pulse(1'b0, 1'b1, 1'b1);
    chk("par_clr", {24'd0, par_cnt}, m_par);
    chk("stp_clr", {24'd0, stp_cnt}, m_stp);

    tmo_run("tmo8", 96);
    cfg(1'b0, 1'b1, 6'd20);
    step();
    step();
    chk_cfg("cfg_post_tmo", 1'b0, 1'b1, 6'd20, 1'b0);
    tmo_run("tmo20", 240);
    cfg(1'b1, 1'b1, 6'd8);
    step();
    step();

    clr_stats();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        push(8'($urandom), ($urandom_range(0, 2) == 0));
      else begin
        rif.rd_ready = ($urandom_range(0, 2) == 0);
        step();
      end
    end
    drain("rand");
    chk("rand_ovf", {31'd0, ovf}, {31'd0, exp_ovf});

    for (int i = 0; i < 3; i++)
      push(8'($urandom), 1'b0);
    err_pulse(1'b1, 1'b0, 1'b0);
    frame_start();
    cfg(1'b0, 1'b0, 6'd33);
    do_reset();
    chk_reset("midframe_reset");
    push(8'hC3, 1'b0);
    chk("post_reset_data", {24'd0, rif.rd_data},
        32'hC3);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin : guard
    #3_000_000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
